// File: rtl/transaction_initiator.sv
// transaction_initiator: moves funds between two balances via a timed request/complete handshake.
// Defining TXN_COUNT_EN adds an 8-bit txn_count output counting committed transfers.
module transaction_initiator #(
  parameter logic [7:0] INIT_P1 = 8'd100,
  parameter logic [7:0] INIT_P2 = 8'd100,
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_person,
  input  logic [7:0] req_amount,
  output logic       txn_valid,
  output logic       txn_person,
  output logic [7:0] txn_amount,
  input  logic       txn_done,
  output logic [7:0] p1_amount,
  output logic [7:0] p2_amount,
  output logic       result_valid,
  output logic       result_ok
`ifdef TXN_COUNT_EN
  ,
  output logic [7:0] txn_count
`endif
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, COMMIT, FAIL} state_t;
  state_t state, next;
  logic [7:0] timer;
  logic [7:0] payer;
  logic [7:0] payee;
  logic reject;
  assign req_ready = state == IDLE;
  assign payer = txn_person ? p2_amount : p1_amount;
  assign payee = txn_person ? p1_amount : p2_amount;
  assign reject = txn_amount == 8'd0 || payer < txn_amount ||
                  ({1'b0, payee} + {1'b0, txn_amount}) > 9'd255;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = req_valid ? CHECK : IDLE;
      CHECK:   next = reject ? FAIL : ISSUE;
      ISSUE:   next = txn_done ? COMMIT : timer == 8'(TIMEOUT - 1) ? FAIL : ISSUE;
      default: next = IDLE;
    endcase
  end
  // Outputs are registered from next so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      timer        <= '0;
      txn_valid    <= 1'b0;
      txn_person   <= 1'b0;
      txn_amount   <= '0;
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      p1_amount    <= INIT_P1;
      p2_amount    <= INIT_P2;
    end else begin
      state        <= next;
      timer        <= state == ISSUE ? timer + 8'd1 : '0;
      txn_valid    <= next == ISSUE;
      result_valid <= next == COMMIT || next == FAIL;
      result_ok    <= next == COMMIT;
      if (req_ready && req_valid) begin
        txn_person <= req_person;
        txn_amount <= req_amount;
      end
      if (next == COMMIT) begin
        p1_amount <= txn_person ? p1_amount + txn_amount : p1_amount - txn_amount;
        p2_amount <= txn_person ? p2_amount - txn_amount : p2_amount + txn_amount;
      end
    end
  end
`ifdef TXN_COUNT_EN
  always_ff @(posedge clock) begin
    if (!resetn) txn_count <= '0;
    else if (next == COMMIT) txn_count <= txn_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_transaction_initiator.sv
// tb_transaction_initiator: scoreboard bench over three instances with different reset balances.
module tb_transaction_initiator;
  localparam int TMO = 16;
  localparam logic [7:0] P1I [3] = '{8'd100, 8'd5, 8'd250};
  localparam logic [7:0] P2I [3] = '{8'd100, 8'd250, 8'd100};
  typedef struct packed {
    logic       ok;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] lat;
  } exp_t;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic req_valid [3];
  logic req_ready [3];
  logic req_person [3];
  logic [7:0] req_amount [3];
  logic txn_valid [3];
  logic txn_person [3];
  logic [7:0] txn_amount [3];
  logic txn_done [3];
  logic [7:0] p1_amount [3];
  logic [7:0] p2_amount [3];
  logic result_valid [3];
  logic result_ok [3];
`ifdef TXN_COUNT_EN
  logic [7:0] txn_count [3];
`endif
  logic [7:0] m1 [3];
  logic [7:0] m2 [3];
  logic [7:0] mc [3];
  exp_t sb [$];
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    transaction_initiator #(.INIT_P1(P1I[g]), .INIT_P2(P2I[g]), .TIMEOUT(TMO)) u_dut (
      .clock(clock),
      .resetn(resetn),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_person(req_person[g]),
      .req_amount(req_amount[g]),
      .txn_valid(txn_valid[g]),
      .txn_person(txn_person[g]),
      .txn_amount(txn_amount[g]),
      .txn_done(txn_done[g]),
      .p1_amount(p1_amount[g]),
      .p2_amount(p2_amount[g]),
      .result_valid(result_valid[g]),
      .result_ok(result_ok[g])
`ifdef TXN_COUNT_EN
      ,
      .txn_count(txn_count[g])
`endif
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m1[k] = P1I[k];
      m2[k] = P2I[k];
      mc[k] = 8'd0;
    end
  endtask
  // delay: cycles after txn_valid before txn_done; 0 means never acknowledge.
  task automatic transfer(input int k, input logic person, input logic [7:0] amt, input int delay);
    logic [7:0] payer;
    logic [7:0] payee;
    logic acc;
    exp_t e;
    int n;
    payer = person ? m2[k] : m1[k];
    payee = person ? m1[k] : m2[k];
    acc = amt != 8'd0 && payer >= amt && ({1'b0, payee} + {1'b0, amt}) <= 9'd255;
    e.ok = acc && delay > 0;
    e.p1 = !e.ok ? m1[k] : person ? m1[k] + amt : m1[k] - amt;
    e.p2 = !e.ok ? m2[k] : person ? m2[k] - amt : m2[k] + amt;
    e.lat = 8'(!acc ? 2 : delay > 0 ? delay + 2 : TMO + 2);
    sb.push_back(e);
    check("ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_person[k] = person;
    req_amount[k] = amt;
    @(posedge clock);
    #1;
    req_valid[k] = 1'b0;
    req_person[k] = ~person;
    req_amount[k] = 8'($urandom);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) check("txn_valid_early", 32'(txn_valid[k]), 32'd0);
      if (n == 2) check("txn_valid_start", 32'(txn_valid[k]), 32'(acc));
      if (txn_valid[k]) begin
        check("txn_amount", 32'(txn_amount[k]), 32'(amt));
        check("txn_person", 32'(txn_person[k]), 32'(person));
      end
      txn_done[k] = acc ? (delay > 0 && n == delay + 1) : (n == 1);
    end while (!result_valid[k] && n < 60);
    txn_done[k] = 1'b0;
    check("result_seen", 32'(result_valid[k]), 32'd1);
    e = sb.pop_front();
    check("latency", 32'(n), 32'(e.lat));
    check("result_ok", 32'(result_ok[k]), 32'(e.ok));
    check("p1_amount", 32'(p1_amount[k]), 32'(e.p1));
    check("p2_amount", 32'(p2_amount[k]), 32'(e.p2));
    if (e.ok) begin
      m1[k] = e.p1;
      m2[k] = e.p2;
      mc[k] = mc[k] + 8'd1;
    end
    @(negedge clock);
    check("result_pulse", 32'(result_valid[k]), 32'd0);
    check("ready_back", 32'(req_ready[k]), 32'd1);
  endtask
  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_person[k] = 1'b0;
      req_amount[k] = 8'd0;
      txn_done[k] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_p1", 32'(p1_amount[k]), 32'(P1I[k]));
      check("rst_p2", 32'(p2_amount[k]), 32'(P2I[k]));
      check("rst_txn_valid", 32'(txn_valid[k]), 32'd0);
      check("rst_result", 32'(result_valid[k]), 32'd0);
      check("rst_ready", 32'(req_ready[k]), 32'd1);
    end
    transfer(0, 1'b0, 8'd30, 3);
    check("p1_after_30", 32'(p1_amount[0]), 32'd70);
    transfer(0, 1'b0, 8'd71, 1);
    transfer(0, 1'b1, 8'd20, 0);
    transfer(0, 1'b0, 8'd0, 1);
    transfer(1, 1'b1, 8'd10, 2);
    transfer(2, 1'b1, 8'd10, 1);
    transfer(0, 1'b1, 8'd30, 4);
    transfer(0, 1'b0, 8'd5, 1);
    check("sum_const", 32'(p1_amount[0]) + 32'(p2_amount[0]), 32'd200);
`ifdef TXN_COUNT_EN
    check("txn_count", 32'(txn_count[0]), 32'(mc[0]));
`endif
    req_valid[0] = 1'b1;
    req_person[0] = 1'b0;
    req_amount[0] = 8'd10;
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!txn_valid[0] && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("rst_issue", 32'(txn_valid[0]), 32'd1);
    resetn = 1'b0;
    txn_done[0] = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    txn_done[0] = 1'b0;
    model_reset();
    check("rst_mid_p1", 32'(p1_amount[0]), 32'(m1[0]));
    check("rst_mid_p2", 32'(p2_amount[0]), 32'(m2[0]));
    check("rst_mid_result", 32'(result_valid[0]), 32'd0);
    check("rst_mid_txn_valid", 32'(txn_valid[0]), 32'd0);
    check("rst_mid_ready", 32'(req_ready[0]), 32'd1);
`ifdef TXN_COUNT_EN
    check("rst_count", 32'(txn_count[0]), 32'd0);
`endif
    @(negedge clock);
    check("rst_no_pulse", 32'(result_valid[0]), 32'd0);
    transfer(0, 1'b1, 8'd40, 2);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
